// File: rtl/apb_cmd_master_if.sv
// Command/response handshake and APB bus bundle for apb_cmd_master.
// master: the APB initiator side; slave: the sequencer/peripheral side.
interface apb_cmd_master_if #(
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int AMBA_WORD       = 32
);
    logic                       cmd_valid;
    logic                       cmd_ready;
    logic                       cmd_write;
    logic [AMBA_ADDR_WIDTH-1:0] cmd_addr;
    logic [AMBA_WORD-1:0]       cmd_wdata;

    logic                       rsp_valid;
    logic                       rsp_ready;
    logic                       rsp_write;
    logic [AMBA_WORD-1:0]       rsp_rdata;
    logic                       rsp_err;

    logic [AMBA_ADDR_WIDTH-1:0] PADDR;
    logic [AMBA_WORD-1:0]       PWDATA;
    logic                       PWRITE;
    logic                       PSEL;
    logic                       PENABLE;
    logic [AMBA_WORD-1:0]       PRDATA;
    logic                       PREADY;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_write, rsp_rdata, rsp_err,
        input  rsp_ready,
        output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        input  PRDATA, PREADY
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_write, rsp_rdata, rsp_err,
        output rsp_ready,
        input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        output PRDATA, PREADY
    );
endinterface

// File: rtl/apb_cmd_master.sv
// APB initiator fed by a command queue, returning one response per transfer.
// Optional ACCESS-phase timeout enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_cmd_master #(
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int AMBA_WORD       = 32,
    parameter int CMD_DEPTH       = 4,
    parameter int TIMEOUT_CYCLES  = 256
) (
    input  logic             clk,
    input  logic             rst,
    apb_cmd_master_if.master bus,
    output logic             busy
);
    localparam int PW = $clog2(CMD_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_RESP
    } state_e;

    state_e state_q, state_d;

    logic [AMBA_ADDR_WIDTH-1:0] addr_mem_q  [CMD_DEPTH];
    logic [AMBA_WORD-1:0]       wdata_mem_q [CMD_DEPTH];
    logic                       write_mem_q [CMD_DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [AMBA_ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [AMBA_WORD-1:0]       pwdata_q, pwdata_d;
    logic                       pwrite_q, pwrite_d;

    logic                 rsp_valid_q, rsp_valid_d;
    logic                 rsp_write_q, rsp_write_d;
    logic [AMBA_WORD-1:0] rsp_rdata_q, rsp_rdata_d;

    logic full, empty, push, pop, load, done, tmo;

    assign full  = (cnt_q == CW'(CMD_DEPTH));
    assign empty = (cnt_q == '0);
    assign push  = bus.cmd_valid && !full;
    assign done  = (state_q == S_ACCESS) && (bus.PREADY || tmo);
    assign pop   = done;

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem_q[wr_ptr_q]  <= bus.cmd_addr;
            wdata_mem_q[wr_ptr_q] <= bus.cmd_wdata;
            write_mem_q[wr_ptr_q] <= bus.cmd_write;
        end
    end

    always_comb begin
        state_d     = state_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pwrite_d    = pwrite_q;
        rsp_valid_d = rsp_valid_q;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;
        load        = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (!empty && !rsp_valid_q) begin
                    state_d = S_SETUP;
                    load    = 1'b1;
                end
            end
            S_SETUP: state_d = S_ACCESS;
            S_ACCESS: begin
                if (done) begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = pwrite_q;
                    // A timed-out read returns zero, not whatever PRDATA shows.
                    rsp_rdata_d = (pwrite_q || !bus.PREADY) ? '0 : bus.PRDATA;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (!empty) begin
                        state_d = S_SETUP;
                        load    = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (load) begin
            paddr_d  = addr_mem_q[rd_ptr_q];
            pwdata_d = wdata_mem_q[rd_ptr_q];
            pwrite_d = write_mem_q[rd_ptr_q];
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        cnt_d    = cnt_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pwrite_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pwrite_q    <= pwrite_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] tmo_cnt_q;
    logic          rsp_err_q;

    // Fires on the last allowed stalled ACCESS cycle; PREADY wins if high.
    assign tmo = (state_q == S_ACCESS) && !bus.PREADY
                 && (tmo_cnt_q == TMO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_q <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            if (state_q == S_SETUP)
                tmo_cnt_q <= '0;
            else if (state_q == S_ACCESS && !bus.PREADY && !tmo)
                tmo_cnt_q <= tmo_cnt_q + TW'(1);
            if (done)
                rsp_err_q <= !bus.PREADY;
        end
    end

    assign bus.rsp_err = rsp_err_q;
`else
    logic unused_tmo_cfg;
    assign unused_tmo_cfg = (TIMEOUT_CYCLES != 0);
    assign tmo            = 1'b0;
    assign bus.rsp_err    = 1'b0;
`endif

    assign bus.cmd_ready = !full;
    assign bus.PADDR     = paddr_q;
    assign bus.PWDATA    = pwdata_q;
    assign bus.PWRITE    = pwrite_q;
    assign bus.PSEL      = (state_q == S_SETUP) || (state_q == S_ACCESS);
    assign bus.PENABLE   = (state_q == S_ACCESS);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_write = rsp_write_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign busy          = !empty || (state_q != S_IDLE);
endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master: drives and samples on the falling edge.
// Timeout steps run only when APB_MASTER_TIMEOUT_EN is defined.
module tb_apb_cmd_master;
    logic clk;
    logic rst;
    logic busy;

    int total;
    int bad;

    logic        prd_fix;
    logic [31:0] prd_val;

    apb_cmd_master_if #(.AMBA_ADDR_WIDTH(20), .AMBA_WORD(32)) bif ();

    apb_cmd_master #(
        .AMBA_ADDR_WIDTH(20),
        .AMBA_WORD(32),
        .CMD_DEPTH(4),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.master),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave read data: fixed value, or a pattern derived from the address.
    always_comb begin
        bif.PRDATA = 32'hC0DE_0000 | {12'h0, bif.PADDR};
        if (prd_fix) bif.PRDATA = prd_val;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_cmd(input logic w, input logic [19:0] a,
                            input logic [31:0] d);
        bif.cmd_valid = 1'b1;
        bif.cmd_write = w;
        bif.cmd_addr  = a;
        bif.cmd_wdata = d;
    endtask

    function automatic logic [31:0] exp_rd(input logic w,
                                           input logic [19:0] a);
        return w ? 32'h0 : (32'hC0DE_0000 | {12'h0, a});
    endfunction

    initial begin
        #300000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int n;
        int got;
        int seen;
        logic acc;
        logic [19:0] ea [5];
        logic        ew [5];

        total = 0;
        bad   = 0;
        rst   = 1'b1;
        prd_fix = 1'b0;
        prd_val = '0;
        bif.cmd_valid = 1'b0;
        bif.cmd_write = 1'b0;
        bif.cmd_addr  = '0;
        bif.cmd_wdata = '0;
        bif.rsp_ready = 1'b1;
        bif.PREADY    = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_psel", 32'(bif.PSEL), 0);
        chk("rst_penable", 32'(bif.PENABLE), 0);
        chk("rst_rsp_valid", 32'(bif.rsp_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_cmd_ready", 32'(bif.cmd_ready), 1);
        chk("rst_paddr", 32'(bif.PADDR), 0);
        rst = 1'b0;
        @(negedge clk);

        // Write 0x00010 <- 0xDEADBEEF, zero-wait slave
        push_cmd(1'b1, 20'h00010, 32'hDEAD_BEEF);
        @(negedge clk);
        bif.cmd_valid = 1'b0;
        chk("w_idle_psel", 32'(bif.PSEL), 0);
        chk("w_busy", 32'(busy), 1);
        @(negedge clk);
        chk("w_setup_psel", 32'(bif.PSEL), 1);
        chk("w_setup_pen", 32'(bif.PENABLE), 0);
        chk("w_paddr", 32'(bif.PADDR), 32'h10);
        chk("w_pwdata", bif.PWDATA, 32'hDEAD_BEEF);
        chk("w_pwrite", 32'(bif.PWRITE), 1);
        @(negedge clk);
        chk("w_acc_psel", 32'(bif.PSEL), 1);
        chk("w_acc_pen", 32'(bif.PENABLE), 1);
        @(negedge clk);
        chk("w_rsp_valid", 32'(bif.rsp_valid), 1);
        chk("w_rsp_write", 32'(bif.rsp_write), 1);
        chk("w_rsp_rdata", bif.rsp_rdata, 0);
        chk("w_rsp_err", 32'(bif.rsp_err), 0);
        chk("w_rsp_psel", 32'(bif.PSEL), 0);
        @(negedge clk);
        chk("w_done_valid", 32'(bif.rsp_valid), 0);
        chk("w_done_busy", 32'(busy), 0);
        chk("w_hold_paddr", 32'(bif.PADDR), 32'h10);

        // Read 0x00014 with three wait states
        prd_fix = 1'b1;
        prd_val = 32'h1234_5678;
        bif.PREADY = 1'b0;
        push_cmd(1'b0, 20'h00014, 32'h0);
        @(negedge clk);
        bif.cmd_valid = 1'b0;
        @(negedge clk);
        chk("r_setup_psel", 32'(bif.PSEL), 1);
        chk("r_paddr", 32'(bif.PADDR), 32'h14);
        chk("r_pwrite", 32'(bif.PWRITE), 0);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bif.PENABLE) begin
                n++;
                if (n == 4) bif.PREADY = 1'b1;
            end else if (n > 0) begin
                break;
            end
        end
        chk("r_pen_cycles", 32'(n), 4);
        chk("r_rsp_valid", 32'(bif.rsp_valid), 1);
        chk("r_rsp_rdata", bif.rsp_rdata, 32'h1234_5678);
        chk("r_rsp_write", 32'(bif.rsp_write), 0);
        chk("r_rsp_err", 32'(bif.rsp_err), 0);
        @(negedge clk);

        // Response back-pressure with a second command queued
        bif.rsp_ready = 1'b0;
        prd_val = 32'hA5A5_0F0F;
        push_cmd(1'b0, 20'h00020, 32'h0);
        @(negedge clk);
        push_cmd(1'b1, 20'h00024, 32'h0000_0011);
        @(negedge clk);
        bif.cmd_valid = 1'b0;
        chk("bp_setup_psel", 32'(bif.PSEL), 1);
        chk("bp_paddr", 32'(bif.PADDR), 32'h20);
        @(negedge clk);
        @(negedge clk);
        chk("bp_rsp_valid", 32'(bif.rsp_valid), 1);
        chk("bp_rsp_rdata", bif.rsp_rdata, 32'hA5A5_0F0F);
        prd_val = 32'h0BAD_0BAD;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", 32'(bif.rsp_valid), 1);
            chk("bp_hold_rdata", bif.rsp_rdata, 32'hA5A5_0F0F);
            chk("bp_hold_write", 32'(bif.rsp_write), 0);
            chk("bp_hold_psel", 32'(bif.PSEL), 0);
        end
        bif.rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_rel_valid", 32'(bif.rsp_valid), 0);
        chk("bp_rel_psel", 32'(bif.PSEL), 1);
        chk("bp_rel_pen", 32'(bif.PENABLE), 0);
        chk("bp_rel_paddr", 32'(bif.PADDR), 32'h24);
        chk("bp_rel_pwdata", bif.PWDATA, 32'h11);
        @(negedge clk);
        @(negedge clk);
        chk("bp2_rsp_valid", 32'(bif.rsp_valid), 1);
        chk("bp2_rsp_write", 32'(bif.rsp_write), 1);
        chk("bp2_rsp_rdata", bif.rsp_rdata, 0);
        @(negedge clk);
        chk("bp2_busy", 32'(busy), 0);
        prd_fix = 1'b0;

        // Five commands into a four-deep queue, slave stalled
        bif.PREADY = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ea[i] = 20'h00100 + 20'(4 * i);
            ew[i] = i[0];
        end
        for (int i = 0; i < 4; i++) begin
            chk("q_ready_open", 32'(bif.cmd_ready), 1);
            push_cmd(ew[i], ea[i], 32'h5000_0000 + 32'(i));
            @(negedge clk);
        end
        push_cmd(ew[4], ea[4], 32'h5000_0004);
        chk("q_full_ready", 32'(bif.cmd_ready), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("q_full_hold", 32'(bif.cmd_ready), 0);
            chk("q_stall_pen", 32'(bif.PENABLE), 1);
        end
        bif.PREADY = 1'b1;
        got = 0;
        acc = 1'b0;
        for (int i = 0; i < 100 && got < 5; i++) begin
            @(negedge clk);
            if (acc) bif.cmd_valid = 1'b0;
            if (bif.cmd_valid && bif.cmd_ready) acc = 1'b1;
            if (bif.rsp_valid) begin
                chk("q_rsp_write", 32'(bif.rsp_write), 32'(ew[got]));
                chk("q_rsp_rdata", bif.rsp_rdata,
                    exp_rd(ew[got], ea[got]));
                chk("q_rsp_paddr", 32'(bif.PADDR), 32'(ea[got]));
                got++;
            end
        end
        chk("q_rsp_count", 32'(got), 5);
        @(negedge clk);
        chk("q_done_busy", 32'(busy), 0);

        // Reset during ACCESS with two commands queued
        bif.PREADY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push_cmd(1'b1, 20'h00200 + 20'(i), 32'h7);
            @(negedge clk);
        end
        bif.cmd_valid = 1'b0;
        chk("rs_pen_before", 32'(bif.PENABLE), 1);
        rst = 1'b1;
        #1;
        chk("rs_psel", 32'(bif.PSEL), 0);
        chk("rs_pen", 32'(bif.PENABLE), 0);
        chk("rs_rsp_valid", 32'(bif.rsp_valid), 0);
        chk("rs_busy", 32'(busy), 0);
        chk("rs_cmd_ready", 32'(bif.cmd_ready), 1);
        @(negedge clk);
        rst = 1'b0;
        bif.PREADY = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bif.rsp_valid || bif.PSEL || busy) seen++;
        end
        chk("rs_quiet_after", 32'(seen), 0);

`ifdef APB_MASTER_TIMEOUT_EN
        // Abandon a stuck read, then a normal read proceeds
        bif.PREADY = 1'b0;
        push_cmd(1'b0, 20'h00040, 32'h0);
        @(negedge clk);
        push_cmd(1'b0, 20'h00044, 32'h0);
        @(negedge clk);
        bif.cmd_valid = 1'b0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bif.PENABLE) n++;
            else if (n > 0) break;
        end
        chk("to_pen_cycles", 32'(n), 8);
        chk("to_rsp_valid", 32'(bif.rsp_valid), 1);
        chk("to_rsp_err", 32'(bif.rsp_err), 1);
        chk("to_rsp_rdata", bif.rsp_rdata, 0);
        chk("to_psel", 32'(bif.PSEL), 0);
        bif.PREADY = 1'b1;
        @(negedge clk);
        chk("to_next_psel", 32'(bif.PSEL), 1);
        chk("to_next_paddr", 32'(bif.PADDR), 32'h44);
        @(negedge clk);
        @(negedge clk);
        chk("to_next_valid", 32'(bif.rsp_valid), 1);
        chk("to_next_err", 32'(bif.rsp_err), 0);
        chk("to_next_rdata", bif.rsp_rdata, 32'hC0DE_0044);
        @(negedge clk);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
